// File: rtl/morse_char_encoder_if.sv
// Character handshake between the text source (master) and the Morse encoder (slave).
interface morse_char_encoder_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/morse_char_encoder.sv
// ASCII-to-Morse keyer: one character per handshake, unit-timed mark/space on key.
// Define MORSE_DIGITS_EN to add '0'..'9'; otherwise digits take the error path.
module morse_char_encoder #(
    parameter int unsigned UNIT_CYCLES = 6_250_000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic                clk,
    input  logic                rst,
    morse_char_encoder_if.slave bus,
    output logic                key,
    output logic                busy,
    output logic                char_err
);
    typedef enum logic [2:0] {IDLE, MARK, SPACE, CGAP, WGAP, ERR} state_t;

    typedef struct packed {
        logic       ok;
        logic       space;
        logic [2:0] len;
        logic [4:0] pat;
    } code_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UNIT_CYCLES - 1);

    // Element i of a pattern is pat[i], sent LSB first; 1 = dash.
    function automatic code_t lookup(input logic [7:0] c);
        logic [7:0] u;
        code_t      r;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        r = '{ok: 1'b1, space: 1'b0, len: 3'd0, pat: 5'd0};
        case (u)
            8'h20: r.space = 1'b1;
            "A": {r.len, r.pat} = {3'd2, 5'b00010};
            "B": {r.len, r.pat} = {3'd4, 5'b00001};
            "C": {r.len, r.pat} = {3'd4, 5'b00101};
            "D": {r.len, r.pat} = {3'd3, 5'b00001};
            "E": {r.len, r.pat} = {3'd1, 5'b00000};
            "F": {r.len, r.pat} = {3'd4, 5'b00100};
            "G": {r.len, r.pat} = {3'd3, 5'b00011};
            "H": {r.len, r.pat} = {3'd4, 5'b00000};
            "I": {r.len, r.pat} = {3'd2, 5'b00000};
            "J": {r.len, r.pat} = {3'd4, 5'b01110};
            "K": {r.len, r.pat} = {3'd3, 5'b00101};
            "L": {r.len, r.pat} = {3'd4, 5'b00010};
            "M": {r.len, r.pat} = {3'd2, 5'b00011};
            "N": {r.len, r.pat} = {3'd2, 5'b00001};
            "O": {r.len, r.pat} = {3'd3, 5'b00111};
            "P": {r.len, r.pat} = {3'd4, 5'b00110};
            "Q": {r.len, r.pat} = {3'd4, 5'b01011};
            "R": {r.len, r.pat} = {3'd3, 5'b00010};
            "S": {r.len, r.pat} = {3'd3, 5'b00000};
            "T": {r.len, r.pat} = {3'd1, 5'b00001};
            "U": {r.len, r.pat} = {3'd3, 5'b00100};
            "V": {r.len, r.pat} = {3'd4, 5'b01000};
            "W": {r.len, r.pat} = {3'd3, 5'b00110};
            "X": {r.len, r.pat} = {3'd4, 5'b01001};
            "Y": {r.len, r.pat} = {3'd4, 5'b01101};
            "Z": {r.len, r.pat} = {3'd4, 5'b00011};
`ifdef MORSE_DIGITS_EN
            "0": {r.len, r.pat} = {3'd5, 5'b11111};
            "1": {r.len, r.pat} = {3'd5, 5'b11110};
            "2": {r.len, r.pat} = {3'd5, 5'b11100};
            "3": {r.len, r.pat} = {3'd5, 5'b11000};
            "4": {r.len, r.pat} = {3'd5, 5'b10000};
            "5": {r.len, r.pat} = {3'd5, 5'b00000};
            "6": {r.len, r.pat} = {3'd5, 5'b00001};
            "7": {r.len, r.pat} = {3'd5, 5'b00011};
            "8": {r.len, r.pat} = {3'd5, 5'b00111};
            "9": {r.len, r.pat} = {3'd5, 5'b01111};
`else
`endif
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       units;
    logic [2:0]       idx;
    logic [2:0]       len_q;
    logic [4:0]       pat_q;
    logic             ready;

    code_t      in_code;
    logic       unit_end;
    logic [1:0] mark_last;

    assign in_code        = lookup(bus.char_data);
    assign unit_end       = (cnt == LAST_CNT);
    assign mark_last      = pat_q[idx] ? 2'd2 : 2'd0;
    assign bus.char_ready = ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            units    <= '0;
            idx      <= '0;
            len_q    <= '0;
            pat_q    <= '0;
            ready    <= 1'b0;
            key      <= 1'b0;
            busy     <= 1'b0;
            char_err <= 1'b0;
        end else begin
            char_err <= 1'b0;
            // Free-running unit timer; every state transition below overrides it with a clear.
            if (unit_end) begin
                cnt   <= '0;
                units <= units + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    cnt   <= '0;
                    units <= '0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    key   <= 1'b0;
                    if (bus.char_valid && ready) begin
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        idx   <= '0;
                        len_q <= in_code.len;
                        pat_q <= in_code.pat;
                        if (!in_code.ok) begin
                            state    <= ERR;
                            char_err <= 1'b1;
                        end else if (in_code.space) begin
                            state <= WGAP;
                        end else begin
                            state <= MARK;
                            key   <= 1'b1;
                        end
                    end
                end

                MARK: begin
                    if (unit_end && units == mark_last) begin
                        cnt   <= '0;
                        units <= '0;
                        key   <= 1'b0;
                        if ((idx + 3'd1) < len_q) begin
                            idx   <= idx + 3'd1;
                            state <= SPACE;
                        end else begin
                            state <= CGAP;
                        end
                    end
                end

                SPACE: begin
                    if (unit_end) begin
                        cnt   <= '0;
                        units <= '0;
                        key   <= 1'b1;
                        state <= MARK;
                    end
                end

                CGAP, WGAP: begin
                    if (unit_end && units == ((state == CGAP) ? 2'd2 : 2'd3)) begin
                        cnt   <= '0;
                        units <= '0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end

                ERR: begin
                    cnt   <= '0;
                    units <= '0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    key   <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_morse_char_encoder.sv
// Scoreboard bench for morse_char_encoder: expected key/err/busy/ready events are queued
// by the stimulus and matched by a monitor against observed edges, in cycles.
module tb_morse_char_encoder;
    localparam int unsigned UNIT = 4;
    localparam int EV_K1 = 0, EV_K0 = 1, EV_ER = 2, EV_BF = 3, EV_RDY = 4;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key, busy, char_err;

    morse_char_encoder_if bus();

    morse_char_encoder #(.UNIT_CYCLES(UNIT), .CNT_W(28)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .key      (key),
        .busy     (busy),
        .char_err (char_err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    ev_t   expq[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    logic  pk = 1'b0, pb = 1'b0, pr = 1'b0;
    string names[5] = '{"key_rise", "key_fall", "char_err", "busy_fall", "ready_rise"};

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic void observe(input int code, input int cyc);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none", names[code], cyc);
            return;
        end
        e = expq.pop_front();
        if (e.code != code || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_order: got %s at cycle %0d expected %s at cycle %0d",
                     names[code], cyc, names[e.code], e.cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (key && !pk)              observe(EV_K1, edge_n);
            if (!key && pk)              observe(EV_K0, edge_n);
            if (char_err)                observe(EV_ER, edge_n);
            if (!busy && pb)             observe(EV_BF, edge_n);
            if (bus.char_ready && !pr)   observe(EV_RDY, edge_n);
        end
        pk = key;
        pb = busy;
        pr = bus.char_ready;
    end

    task automatic exp_ev(input int code, input int cyc);
        ev_t e;
        e.code = code;
        e.cyc  = cyc;
        expq.push_back(e);
    endtask

    task automatic exp_done(input int cyc);
        exp_ev(EV_BF, cyc);
        exp_ev(EV_RDY, cyc);
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.char_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: char_ready got 0 for 300 cycles expected 1");
        end
    endtask

    task automatic present(input logic [7:0] c, output int b);
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        b = edge_n;
    endtask

    task automatic drop_valid();
        @(posedge clk);
        #1 bus.char_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && expq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(name, expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int marks;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_key", key, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.char_ready, 0);
        chk("rst_err", char_err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.char_ready, 1);
        #1 mon_en = 1'b1;

        // 'E': one dot then the character gap
        present("E", b);
        exp_ev(EV_K1, b + 1); exp_ev(EV_K0, b + 5); exp_done(b + 17);
        drop_valid();
        drain("E_pending");

        // lowercase 'a' folds to .-
        present("a", b);
        exp_ev(EV_K1, b + 1); exp_ev(EV_K0, b + 5);
        exp_ev(EV_K1, b + 9); exp_ev(EV_K0, b + 21); exp_done(b + 33);
        drop_valid();
        drain("a_pending");

        // 'Q' --.-: four elements, dash last
        present("Q", b);
        exp_ev(EV_K1, b + 1);  exp_ev(EV_K0, b + 13);
        exp_ev(EV_K1, b + 17); exp_ev(EV_K0, b + 29);
        exp_ev(EV_K1, b + 33); exp_ev(EV_K0, b + 37);
        exp_ev(EV_K1, b + 41); exp_ev(EV_K0, b + 53); exp_done(b + 65);
        drop_valid();
        drain("Q_pending");

        // SOS with char_valid held high throughout
        present("S", b);
        exp_ev(EV_K1, b + 1);   exp_ev(EV_K0, b + 5);
        exp_ev(EV_K1, b + 9);   exp_ev(EV_K0, b + 13);
        exp_ev(EV_K1, b + 17);  exp_ev(EV_K0, b + 21);  exp_done(b + 33);
        exp_ev(EV_K1, b + 34);  exp_ev(EV_K0, b + 46);
        exp_ev(EV_K1, b + 50);  exp_ev(EV_K0, b + 62);
        exp_ev(EV_K1, b + 66);  exp_ev(EV_K0, b + 78);  exp_done(b + 90);
        exp_ev(EV_K1, b + 91);  exp_ev(EV_K0, b + 95);
        exp_ev(EV_K1, b + 99);  exp_ev(EV_K0, b + 103);
        exp_ev(EV_K1, b + 107); exp_ev(EV_K0, b + 111); exp_done(b + 123);
        wait_ready();
        bus.char_data = "O";
        wait_ready();
        bus.char_data = "S";
        drop_valid();
        drain("SOS_pending");

        // unsupported '?'
        present(8'h3F, b);
        exp_ev(EV_ER, b + 1); exp_done(b + 2);
        drop_valid();
        drain("qmark_pending");

        // word gap then 'T'
        present(" ", b);
        exp_done(b + 17);
        exp_ev(EV_K1, b + 18); exp_ev(EV_K0, b + 30); exp_done(b + 42);
        drop_valid();
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_data  = "T";
        drop_valid();
        drain("spaceT_pending");

        present("5", b);
`ifdef MORSE_DIGITS_EN
        for (int i = 0; i < 5; i++) begin
            exp_ev(EV_K1, b + 1 + 8 * i);
            exp_ev(EV_K0, b + 5 + 8 * i);
        end
        exp_done(b + 49);
`else
        exp_ev(EV_ER, b + 1); exp_done(b + 2);
`endif
        drop_valid();
        drain("digit5_pending");

        // reset in the middle of a dash
        present("T", b);
        exp_ev(EV_K1, b + 1);
        drop_valid();
        while (edge_n < b + 5) @(negedge clk);
        chk("key_before_rst", key, 1);
        chk("T_pending", expq.size(), 0);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_key", key, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", bus.char_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.char_ready, 1);
        chk("post_rst_busy", busy, 0);
        #1 mon_en = 1'b1;
        marks = 0;
        repeat (20) begin
            @(negedge clk);
            if (key) marks++;
        end
        chk("residual_marks", marks, 0);
        chk("final_pending", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
